// File: rtl/crc32_mpeg2_pkg.sv
// crc32_mpeg2_pkg: shared CRC-32/MPEG-2 constants and checker state type
package crc32_mpeg2_pkg;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam int CRC_LEN = 32;
  typedef enum logic [1:0] {IDLE, RECV, GAP, REPORT} chk_state_t;
endpackage

// File: rtl/crc32_mpeg2_lfsr.sv
// crc32_mpeg2_lfsr: MSB-first serial CRC-32/MPEG-2 engine
// Ports: clk, rst (async, active-high), clr (sync load of CRC_INIT), en (absorb d), d (serial bit), crc (running value)
module crc32_mpeg2_lfsr
  import crc32_mpeg2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        d,
  output logic [31:0] crc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en) crc <= {crc[30:0], 1'b0} ^ ((crc[31] ^ d) ? CRC_POLY : 32'h0);
endmodule

// File: rtl/crc32_mpeg2_checker.sv
// crc32_mpeg2_checker: bit-serial receive CRC-32/MPEG-2 frame checker
// Ports: clk_in/rst_in (async, active-high); data_valid_in/data_in serial frame bits, MSB-first;
//   busy_out frame in progress; frame_done_out one-cycle result strobe; crc_ok_out, runt_out,
//   overlong_out, crc_rx_out, crc_calc_out, frame_bits_out results of the last frame, held.
// Optional: CRC32_MPEG2_CHECKER_STATS_EN adds good_frames_out/bad_frames_out wrapping counters.
module crc32_mpeg2_checker
  import crc32_mpeg2_pkg::*;
#(
  parameter int GAP_CYCLES       = 4,
  parameter int MIN_PAYLOAD_BITS = 8,
  parameter int MAX_BITS         = 12000,
  parameter int LEN_W            = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic             data_in,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic             crc_ok_out,
  output logic             runt_out,
  output logic             overlong_out,
  output logic [31:0]      crc_rx_out,
  output logic [31:0]      crc_calc_out,
  output logic [LEN_W-1:0] frame_bits_out
`ifdef CRC32_MPEG2_CHECKER_STATS_EN
  ,
  output logic [15:0]      good_frames_out,
  output logic [15:0]      bad_frames_out
`endif
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_BITS + 1);
  localparam logic [LEN_W-1:0] CNT_OVL = LEN_W'(MAX_BITS);
  localparam logic [LEN_W-1:0] CNT_FEED = LEN_W'(CRC_LEN);
  localparam logic [LEN_W-1:0] CNT_RUNT = LEN_W'(CRC_LEN + MIN_PAYLOAD_BITS);
  chk_state_t state, nxt;
  logic [31:0] sr, crc;
  logic [LEN_W-1:0] count;
  logic [GW-1:0] gap;
  logic overlong, start, accept, feed, last_low;
  assign start = data_valid_in && state == IDLE;
  assign accept = data_valid_in && (state == RECV || state == GAP);
  // the bit leaving a full delay line is payload, so it enters the CRC engine
  assign feed = accept && count >= CNT_FEED;
  assign last_low = (state == RECV) ? (GAP_LAST == '0) : (gap == GAP_LAST);
  assign busy_out = state != IDLE;
  assign frame_done_out = state == REPORT;
  crc32_mpeg2_lfsr u_lfsr (
    .clk(clk_in),
    .rst(rst_in),
    .clr(start),
    .en (feed),
    .d  (sr[31]),
    .crc(crc)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = data_valid_in ? RECV : IDLE;
      RECV, GAP: nxt = data_valid_in ? RECV : (last_low ? REPORT : GAP);
      REPORT:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state          <= IDLE;
      sr             <= '0;
      count          <= '0;
      gap            <= '0;
      overlong       <= 1'b0;
      crc_ok_out     <= 1'b0;
      runt_out       <= 1'b0;
      overlong_out   <= 1'b0;
      crc_rx_out     <= '0;
      crc_calc_out   <= '0;
      frame_bits_out <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        sr       <= {31'b0, data_in};
        count    <= LEN_W'(1);
        overlong <= 1'b0;
      end else if (accept) begin
        sr       <= {sr[30:0], data_in};
        count    <= (count == CNT_SAT) ? count : count + 1'b1;
        overlong <= overlong | (count >= CNT_OVL);
      end
      if (!data_valid_in && (state == RECV || state == GAP))
        gap <= (state == RECV) ? GW'(1) : gap + 1'b1;
      if (nxt == REPORT) begin
        crc_ok_out     <= !(count < CNT_RUNT) && !overlong && sr == crc;
        runt_out       <= count < CNT_RUNT;
        overlong_out   <= overlong;
        crc_rx_out     <= sr;
        crc_calc_out   <= crc;
        frame_bits_out <= count;
      end
    end
`ifdef CRC32_MPEG2_CHECKER_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      good_frames_out <= '0;
      bad_frames_out  <= '0;
    end else if (state == REPORT) begin
      good_frames_out <= good_frames_out + {15'b0, crc_ok_out};
      bad_frames_out  <= bad_frames_out + {15'b0, !crc_ok_out};
    end
`endif
endmodule
